uart_rx_16x: RTL and testbench
==============================

Name: uart_rx_16x

Overview:
- UART receiver. Consumes the 16x-baud tick from the clock handler and recovers bytes from the asynchronous serial line.
- Sits directly downstream of the baud tick generator and upstream of the command/character decoder that drives the VGA text path.
- Frame format: 1 start bit, DATA_BITS data bits LSB first, optional parity bit, 1 stop bit.

Parameters:
- DATA_BITS, 8, data bits per frame (5..8).
- OVERSAMPLE, 16, ticks per bit; must be even; counter width is clog2(OVERSAMPLE).

Ports:
- clk  in  1  system clock (100 MHz).
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- clk_16bd  in  1  16x-baud tick from the clock handler; a level or pulse train, rising edge detected internally.
- rx  in  1  asynchronous serial input; idles high.
- data_out  out  DATA_BITS  last correctly received word; held until the next good frame.
- rx_valid  out  1  one-clk pulse when data_out updates.
- frame_err  out  1  one-clk pulse when the stop bit is sampled low.
- parity_err  out  1  one-clk pulse on parity mismatch; tied 0 when the feature is absent.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Input conditioning:
  - rx passes through a 2-FF synchronizer; rx_s is the second stage.
  - tick = clk_16bd & ~clk_16bd_q, where clk_16bd_q is a 1-clk delayed copy.
  - All FSM advances occur only on cycles with tick = 1.
- Reset (synchronous): state = IDLE, sample counter = 0, bit counter = 0, shift register = 0, data_out = 0, rx_valid = frame_err = parity_err = busy = 0, synchronizer flops = 1, clk_16bd_q = 0.
- IDLE:
  - On a tick where rx_s = 0 → START, counter = 0.
  - rx_s is checked on ticks only, so a low shorter than one tick may be missed.
- START:
  - Count ticks. When counter reaches OVERSAMPLE/2 − 1 (7), sample rx_s.
  - rx_s = 0 → DATA, counter = 0, bit counter = 0.
  - rx_s = 1 → false start; return to IDLE with no outputs pulsed.
- DATA:
  - When counter reaches OVERSAMPLE − 1 (15), sample rx_s into the shift register MSB and shift right; counter wraps to 0.
  - After DATA_BITS samples → PARITY (feature enabled) or STOP.
- STOP:
  - Sample at counter = OVERSAMPLE − 1.
  - rx_s = 1 and no parity error: data_out ← shift register; rx_valid pulses 1 clk in the cycle after the sample tick.
  - rx_s = 0: frame_err pulses 1 clk; data_out is unchanged.
  - Either way → IDLE.
  - A line held low (break) therefore yields one frame_err, then re-arms only when rx_s is seen high and then low again on ticks. IDLE must require a high-then-low edge seen on ticks, not just a low level.
- Counters:
  - Sample counter wraps at OVERSAMPLE − 1.
  - Bit counter is sized for DATA_BITS and never wraps past DATA_BITS.
- Back-to-back frames: a new start bit arriving immediately after the stop-bit sample is accepted. Frame-to-frame latency is zero idle bits.
- Reset asserted mid-frame aborts immediately to the reset state; no pulses are emitted.
- Simultaneous reset and tick: reset wins.
- Error and valid pulses are mutually exclusive in any cycle.
- Latency: rx_valid fires 1 clk after the tick that samples the stop-bit midpoint, about 9.5 bit periods after the start edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - A PARITY state follows DATA and samples one bit at mid-bit.
  - Even parity: mismatch when (^shift register) ^ sampled bit = 1.
  - On a mismatch, STOP still executes. Instead of rx_valid, parity_err pulses 1 clk, and data_out is unchanged.
  - If the stop bit is also low, frame_err and parity_err pulse in the same cycle.
- When undefined: no PARITY state, parity_err is tied 0, and the frame is 10 bits.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP.
  - OVERSAMPLE default.
  - Baud index constants matching the clock handler's select codes.
- Sub-module sync_2ff: generic 2-flop synchronizer with a reset value parameter. Reused for rx and, later, for other asynchronous inputs.

Test Plan:
- For speed, drive clk_16bd as a 1-clk pulse every 4 clks; bit period = 64 clks. All response times below are at this tick rate.
- Frame 0xA5, stop = 1 → data_out = 0xA5, rx_valid pulses once, no errors, busy falls the same cycle.
- rx low for 4 ticks, then high → no rx_valid, no frame_err, state back in IDLE, data_out unchanged.
- Frame 0x3C with stop = 0 → frame_err pulses once, data_out keeps its prior value; holding rx low 3 more bit times → no further pulses.
- Back-to-back 0x00 then 0xFF, no idle gap → two rx_valid pulses 640 clks apart, data_out = 0x00, then 0xFF.
- Reset asserted mid data bit 4, released, then a clean 0x5A frame → busy drops the cycle after reset, no stray pulse, then data_out = 0x5A.
- With UART_RX_PARITY_EN, frame 0x07 sent with parity bit 0 (wrong; even parity requires 1) → parity_err pulses, rx_valid stays 0; resent with parity bit 1 → rx_valid pulses, data_out = 0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding, oversample default,
// baud select codes shared with the clock handler.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int UART_OVERSAMPLE = 16;

  // Baud select codes, identical to the clock handler's select input.
  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  // Ticks from a detected start edge to the start-bit midpoint sample.
  function automatic int half_bit_ticks(input int os);
    return os / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs, with a
// configurable reset value so idle-high lines come out of reset idle.
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops; only q is safe to use downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx_16x.sv
// UART receiver on a 16x-baud tick: start/data/[parity]/stop framing,
// LSB first. Define UART_RX_PARITY_EN to add an even-parity bit check.
module uart_rx_16x
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_16bd,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] HALF_M1  = CW'(half_bit_ticks(OVERSAMPLE) - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic rx_s;
  logic clk_16bd_q;
  logic tick;

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 vld_q, vld_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_prev_q, rx_prev_d;
  logic                 par_bad;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  // Rising-edge detect on the baud tick input.
  always_ff @(posedge clk) begin
    if (rst) clk_16bd_q <= 1'b0;
    else     clk_16bd_q <= clk_16bd;
  end

  assign tick = clk_16bd & ~clk_16bd_q;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic perr_q, perr_d;
  assign par_bad    = par_bad_q;
  assign parity_err = perr_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Next-state and datapath: nothing moves except on a tick; pulses default low.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    data_d    = data_q;
    vld_d     = 1'b0;
    ferr_d    = 1'b0;
    rx_prev_d = rx_prev_q;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (tick) begin
      // Line level as last seen on a tick; IDLE needs high-then-low.
      rx_prev_d = rx_s;
      case (state_q)
        ST_IDLE: begin
          if (rx_prev_q && !rx_s) begin
            state_d = ST_START;
            cnt_d   = '0;
          end
        end
        ST_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_d = '0;
            bit_d = '0;
            // Still low at mid start bit: genuine start, else glitch.
            state_d = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        ST_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_d = '0;
            sh_d  = {rx_s, sh_q[DATA_BITS-1:1]};
            if (bit_q == LAST_BIT) begin
              bit_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d = ST_PARITY;
`else
              state_d = ST_STOP;
`endif
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_d     = '0;
            par_bad_d = (^sh_q) ^ rx_s;
            state_d   = ST_STOP;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
`endif
        ST_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            ferr_d  = ~rx_s;
            if (rx_s && !par_bad) begin
              data_d = sh_q;
              vld_d  = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            perr_d = par_bad_q;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset aborts any frame without pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
      rx_prev_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      ferr_q    <= ferr_d;
      rx_prev_q <= rx_prev_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign data_out  = data_q;
  assign rx_valid  = vld_q;
  assign frame_err = ferr_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_16x.sv
// Scoreboard bench for uart_rx_16x: frames are queued with their expected
// outcome when sent; a monitor pops and compares on every output pulse.
module tb_uart_rx_16x;

  localparam int DB = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clk_16bd = 1'b0;
  logic          rx = 1'b1;
  logic [DB-1:0] data_out;
  logic          rx_valid, frame_err, parity_err, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    bit          vld;
    bit          ferr;
    bit          perr;
    logic [DB-1:0] data;
  } exp_t;

  exp_t          sb_q[$];
  logic [DB-1:0] last_good = '0;
  int            last_vld_cyc = 0;
  int            frame_start_cyc = 0;

  uart_rx_16x #(.DATA_BITS(DB), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .clk_16bd   (clk_16bd),
    .rx         (rx),
    .data_out   (data_out),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 1-clk tick every 4 clks: bit period = 16 ticks = 64 clks.
  initial begin
    forever begin
      repeat (3) @(negedge clk);
      clk_16bd = 1'b1;
      @(negedge clk);
      clk_16bd = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference outcome of one frame from the framing rules alone.
  task automatic push_expect(input logic [DB-1:0] d, input bit par, input bit stop);
    exp_t e;
    bit par_ok;
    par_ok = !PAR_EN || (((^d) ^ par) == 1'b0);
    e.vld  = stop && par_ok;
    e.ferr = !stop;
    e.perr = !par_ok;
    if (e.vld) last_good = d;
    e.data = last_good;
    sb_q.push_back(e);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) @(posedge clk_16bd);
  endtask

  task automatic send_bit(input bit b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input bit par, input bit stop);
    push_expect(d, par, stop);
    frame_start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    if (PAR_EN) send_bit(par);
    send_bit(stop);
  endtask

  // Monitor: every output pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rx_valid || frame_err || parity_err) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got v=%0b f=%0b p=%0b expected no pulse",
                 rx_valid, frame_err, parity_err);
      end else begin
        e = sb_q.pop_front();
        chk("pulse_kind", {29'd0, rx_valid, frame_err, parity_err}, {29'd0, e.vld, e.ferr, e.perr});
        chk("data_out", 32'(data_out), 32'(e.data));
        if (rx_valid) chk("busy_at_valid", 32'(busy), 32'd0);
      end
      if (rx_valid) last_vld_cyc = cyc;
    end
  end

  initial begin : watchdog
    #3000000;
    bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stim
    int c1;
    logic [DB-1:0] d;
    bit stop, par;
    int idle;

    rst = 1'b1;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_parity_err", 32'(parity_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_ticks(3);

    // Clean frame
    send_frame(8'hA5, ^8'hA5, 1'b1);
    chk("a5_latency_ok", 32'((last_vld_cyc - frame_start_cyc) >= 600 &&
                             (last_vld_cyc - frame_start_cyc) <= 625), 32'd1);
    wait_ticks(2);
    chk("a5_idle_busy", 32'(busy), 32'd0);

    // Glitch shorter than half a bit: false start, nothing reported
    rx = 1'b0;
    wait_ticks(4);
    rx = 1'b1;
    wait_ticks(20);
    chk("glitch_busy", 32'(busy), 32'd0);
    chk("glitch_data", 32'(data_out), 32'hA5);

    // Bad stop bit, then line held low (break) for 3 more bits
    send_frame(8'h3C, ^8'h3C, 1'b0);
    wait_ticks(48);
    chk("break_busy", 32'(busy), 32'd0);
    rx = 1'b1;
    wait_ticks(16);
    chk("break_data", 32'(data_out), 32'hA5);

    // Back-to-back, no idle gap
    send_frame(8'h00, 1'b0, 1'b1);
    c1 = last_vld_cyc;
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_ticks(2);
    chk("b2b_spacing", 32'(last_vld_cyc - c1), 32'd640);

    // Reset in the middle of data bit 4 aborts the frame
    d = 8'h96;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    wait_ticks(8);
    chk("midframe_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    chk("reset_busy_drop", 32'(busy), 32'd0);
    chk("reset_data_clear", 32'(data_out), 32'd0);
    last_good = '0;
    @(negedge clk);
    rst = 1'b0;
    wait_ticks(4);
    send_frame(8'h5A, ^8'h5A, 1'b1);
    wait_ticks(2);

`ifdef UART_RX_PARITY_EN
    // Wrong parity then correct parity
    send_frame(8'h07, 1'b0, 1'b1);
    wait_ticks(2);
    send_frame(8'h07, 1'b1, 1'b1);
    wait_ticks(2);
    send_frame(8'h07, 1'b0, 1'b0);
    rx = 1'b1;
    wait_ticks(4);
`endif

    // Randomized frames
    for (int n = 0; n < 14; n++) begin
      d    = DB'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      par  = PAR_EN ? (($urandom_range(0, 3) == 0) ? ~(^d) : (^d)) : 1'b0;
      send_frame(d, par, stop);
      idle = stop ? $urandom_range(0, 6) : $urandom_range(2, 6);
      rx = 1'b1;
      wait_ticks(idle);
    end

    wait_ticks(40);
    chk("end_busy", 32'(busy), 32'd0);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
